// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle for uart_rx_cfg: word, status flags and the
// consumer's ready. The receiver drives through master; the consumer uses slave.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_break;
    logic                 rx_busy;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err,
               rx_overrun, rx_break, rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err,
               rx_overrun, rx_break, rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..8 data bits, none/odd/even parity, 1..2 stop bits,
// 3-sample majority vote, valid/ready output. Define UART_RX_BREAK_EN for break detection.
module uart_rx_cfg #(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin,
    uart_rx_cfg_if.master rx
);
    localparam int unsigned CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] HALF      = 16'(CYCLE / 2);
    localparam logic [15:0] HALF_M1   = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] HALF_M2   = 16'(CYCLE / 2 - 2);
    localparam logic [15:0] LAST      = 16'(CYCLE - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, BRK_WAIT} state_t;

    state_t               state;
    logic                 sync1, rx_s, rx_d;
    logic [15:0]          cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, par_err, frame_err;
    logic                 s0, s1;
    logic                 vote, at_mid, at_last, frame_err_now;
`ifdef UART_RX_BREAK_EN
    logic                 all_zero;
`else
    assign rx.rx_break = 1'b0;
`endif

    always_comb begin
        vote          = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        at_mid        = (cnt == HALF);
        at_last       = (cnt == LAST);
        frame_err_now = frame_err | ~vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            sync1            <= 1'b1;
            rx_s             <= 1'b1;
            rx_d             <= 1'b1;
            cnt              <= '0;
            bit_idx          <= '0;
            stop_idx         <= 1'b0;
            shreg            <= '0;
            par_acc          <= 1'b0;
            par_err          <= 1'b0;
            frame_err        <= 1'b0;
            s0               <= 1'b1;
            s1               <= 1'b1;
            rx.rx_data       <= '0;
            rx.rx_valid      <= 1'b0;
            rx.rx_parity_err <= 1'b0;
            rx.rx_frame_err  <= 1'b0;
            rx.rx_overrun    <= 1'b0;
            rx.rx_busy       <= 1'b0;
`ifdef UART_RX_BREAK_EN
            rx.rx_break      <= 1'b0;
            all_zero         <= 1'b0;
`endif
        end else begin
            sync1         <= rx_pin;
            rx_s          <= sync1;
            rx_d          <= rx_s;
            rx.rx_overrun <= 1'b0;
`ifdef UART_RX_BREAK_EN
            rx.rx_break   <= 1'b0;
`endif
            if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
            if (cnt == HALF_M2) s0 <= rx_s;
            if (cnt == HALF_M1) s1 <= rx_s;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_d && !rx_s) begin
                        state      <= START;
                        rx.rx_busy <= 1'b1;
                    end
                end
                START: begin
                    cnt <= cnt + 16'd1;
                    if (at_mid && vote) begin
                        state      <= IDLE;
                        rx.rx_busy <= 1'b0;
                        cnt        <= '0;
                    end else if (at_last) begin
                        state     <= DATA;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        par_acc   <= 1'b0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
`ifdef UART_RX_BREAK_EN
                        all_zero  <= 1'b1;
`endif
                    end
                end
                DATA: begin
                    cnt <= cnt + 16'd1;
                    if (at_mid) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ vote;
`ifdef UART_RX_BREAK_EN
                        if (vote) all_zero <= 1'b0;
`endif
                    end
                    if (at_last) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? PAR_BIT : STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                end
                PAR_BIT: begin
                    cnt <= cnt + 16'd1;
                    if (at_mid) begin
                        par_err <= (PARITY == 1) ? ~(par_acc ^ vote) : (par_acc ^ vote);
`ifdef UART_RX_BREAK_EN
                        if (vote) all_zero <= 1'b0;
`endif
                    end
                    if (at_last) begin
                        state <= STOP;
                        cnt   <= '0;
                    end
                end
                STOP: begin
                    cnt <= cnt + 16'd1;
                    if (at_mid) begin
                        frame_err <= frame_err_now;
`ifdef UART_RX_BREAK_EN
                        if (!stop_idx && all_zero && !vote) begin
                            rx.rx_break <= 1'b1;
                            state       <= BRK_WAIT;
                            cnt         <= '0;
                        end else
`endif
                        // Commit at the last stop decision point rather than the bit end to absorb baud drift.
                        if (stop_idx == LAST_STOP) begin
                            state      <= IDLE;
                            rx.rx_busy <= 1'b0;
                            cnt        <= '0;
                            if (!rx.rx_valid || rx.rx_ready) begin
                                rx.rx_data       <= shreg;
                                rx.rx_parity_err <= par_err;
                                rx.rx_frame_err  <= frame_err_now;
                                rx.rx_valid      <= 1'b1;
                            end else begin
                                rx.rx_overrun <= 1'b1;
                            end
                        end
                    end else if (at_last) begin
                        cnt      <= '0;
                        stop_idx <= 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_EN
                BRK_WAIT: begin
                    if (rx_s) begin
                        state      <= IDLE;
                        rx.rx_busy <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: A = 8 data/even/1 stop, B = 6 data/odd/2 stop.
// Frames are decoded by a line-level model; a negedge monitor pops expectations on accept.
module tb_uart_rx_cfg;
    localparam int CYC  = 27 * 1000000 / 115200;
    localparam int HALF = CYC / 2;

    typedef struct packed {
        bit       brk;
        bit [7:0] d;
        bit       pe;
        bit       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_a, rx_b;
    int   n_chk = 0, n_fail = 0;
    int   ov_exp = 0, ov_seen = 0, brk_exp = 0, brk_seen = 0;
    bit   held [2];
    exp_t qa[$], qb[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_rx_cfg_if #(.DATA_BITS(6)) ifb ();

    uart_rx_cfg #(.CLK_FRE(27), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .rx_pin(rx_a), .rx(ifa));
    uart_rx_cfg #(.CLK_FRE(27), .BAUD_RATE(115200), .DATA_BITS(6), .PARITY(1), .STOP_BITS(2))
        dut_b (.clk(clk), .rst_n(rst_n), .rx_pin(rx_b), .rx(ifb));

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int db_of(int w);  return (w == 0) ? 8 : 6; endfunction
    function automatic int par_of(int w); return (w == 0) ? 2 : 1; endfunction
    function automatic int sb_of(int w);  return (w == 0) ? 1 : 2; endfunction
    function automatic int nbits(int w);
        return 1 + db_of(w) + ((par_of(w) != 0) ? 1 : 0) + sb_of(w);
    endfunction

    // Line bits of one frame: start, data LSB first, parity (correct unless flipped), stops.
    function automatic bit [15:0] build(int w, bit [7:0] d, bit flip, bit [1:0] stops);
        bit [15:0] fb;
        int        ones;
        bit        pb;
        fb    = '1;
        fb[0] = 1'b0;
        ones  = 0;
        for (int i = 0; i < db_of(w); i++) begin
            fb[1+i] = d[i];
            if (d[i]) ones++;
        end
        pb = (par_of(w) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        pb = pb ^ flip;
        if (par_of(w) != 0) fb[1+db_of(w)] = pb;
        for (int k = 0; k < sb_of(w); k++)
            fb[1+db_of(w)+((par_of(w) != 0) ? 1 : 0)+k] = stops[k];
        return fb;
    endfunction

    // What a receiver must report for a given line pattern.
    function automatic exp_t decode(int w, bit [15:0] fb);
        exp_t e;
        int   ones, s0;
        bit   pb;
        e  = '0;
        pb = 1'b0;
        for (int i = 0; i < db_of(w); i++) e.d[i] = fb[1+i];
        if (par_of(w) != 0) pb = fb[1+db_of(w)];
        ones = $countones(e.d) + int'(pb);
        if (par_of(w) == 1) e.pe = (ones % 2 == 0);
        else if (par_of(w) == 2) e.pe = (ones % 2 == 1);
        s0 = 1 + db_of(w) + ((par_of(w) != 0) ? 1 : 0);
        for (int k = 0; k < sb_of(w); k++) if (!fb[s0+k]) e.fe = 1'b1;
        e.brk = (e.d == 0) && (par_of(w) == 0 || !pb) && !fb[s0];
        return e;
    endfunction

    task automatic expect_frame(int w, bit [15:0] fb);
        exp_t e;
        logic rdy;
        e = decode(w, fb);
`ifdef UART_RX_BREAK_EN
        if (e.brk) begin
            brk_exp++;
            return;
        end
`endif
        rdy = (w == 0) ? ifa.rx_ready : ifb.rx_ready;
        if (!rdy && held[w]) ov_exp++;
        else begin
            if (w == 0) qa.push_back(e); else qb.push_back(e);
            held[w] = !rdy;
        end
    endtask

    task automatic set_pin(int w, logic v);
        if (w == 0) rx_a = v; else rx_b = v;
    endtask

    task automatic set_ready(int w, logic v);
        @(posedge clk);
        #1;
        if (w == 0) ifa.rx_ready = v; else ifb.rx_ready = v;
        if (v) held[w] = 1'b0;
    endtask

    task automatic send(int w, bit [15:0] fb, int n, bit spike);
        for (int i = 0; i < n; i++) begin
            int off = $urandom_range(CYC - 2, 1);
            for (int c = 0; c < CYC; c++) begin
                @(negedge clk);
                set_pin(w, (spike && i >= 1 && i <= db_of(w) && c == off) ? ~fb[i] : fb[i]);
            end
        end
        @(negedge clk);
        set_pin(w, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic frame(int w, bit [7:0] d, bit flip, bit [1:0] stops, bit spike);
        bit [15:0] fb;
        fb = build(w, d, flip, stops);
        expect_frame(w, fb);
        send(w, fb, nbits(w), spike);
        chk((w == 0) ? "busy_after_frame_A" : "busy_after_frame_B",
            32'((w == 0) ? ifa.rx_busy : ifb.rx_busy), 32'd0);
    endtask

    task automatic random_frames(int w, int count);
        for (int i = 0; i < count; i++) begin
            bit [7:0] d;
            bit [1:0] st;
            d  = (w == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(63));
            if (d == 0) d = 8'd1;
            st = {($urandom_range(4) != 0), ($urandom_range(4) != 0)};
            frame(w, d, ($urandom_range(3) == 0), st, 1'($urandom_range(1)));
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ifa.rx_valid && ifa.rx_ready) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_word_A: got 0x%0h, expected no word", ifa.rx_data);
            end else begin
                e = qa.pop_front();
                chk("word_A_data", 32'(ifa.rx_data), 32'(e.d));
                chk("word_A_parity_err", 32'(ifa.rx_parity_err), 32'(e.pe));
                chk("word_A_frame_err", 32'(ifa.rx_frame_err), 32'(e.fe));
            end
        end
        if (ifb.rx_valid && ifb.rx_ready) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_word_B: got 0x%0h, expected no word", ifb.rx_data);
            end else begin
                e = qb.pop_front();
                chk("word_B_data", 32'(ifb.rx_data), 32'(e.d));
                chk("word_B_parity_err", 32'(ifb.rx_parity_err), 32'(e.pe));
                chk("word_B_frame_err", 32'(ifb.rx_frame_err), 32'(e.fe));
            end
        end
        if (ifa.rx_overrun) ov_seen++;
        if (ifb.rx_overrun) ov_seen++;
        if (ifa.rx_break) brk_seen++;
        if (ifb.rx_break) brk_seen++;
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        ifa.rx_ready = 1'b1;
        ifb.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_outputs_A", 32'({ifa.rx_data, ifa.rx_valid, ifa.rx_parity_err, ifa.rx_frame_err,
                                    ifa.rx_overrun, ifa.rx_break, ifa.rx_busy}), 32'd0);
        chk("reset_outputs_B", 32'({ifb.rx_data, ifb.rx_valid, ifb.rx_parity_err, ifb.rx_frame_err,
                                    ifb.rx_overrun, ifb.rx_break, ifb.rx_busy}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        frame(0, 8'hA5, 1'b0, 2'b11, 1'b0);
        chk("valid_single_pulse_A", 32'(ifa.rx_valid), 32'd0);
        frame(0, 8'h07, 1'b1, 2'b11, 1'b0);
        frame(0, 8'h07, 1'b0, 2'b11, 1'b0);

        // 50-clock low glitch on an idle line must be rejected at the start-bit vote.
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            rx_a = (c >= 50);
            if (c == 60)  chk("glitch_busy_A", 32'(ifa.rx_busy), 32'd1);
            if (c == 135) chk("glitch_back_idle_A", 32'(ifa.rx_busy), 32'd0);
        end
        frame(0, 8'h00, 1'b0, 2'b11, 1'b1);

        set_ready(0, 1'b0);
        frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
        frame(0, 8'h22, 1'b0, 2'b11, 1'b0);
        chk("held_word_A", 32'(ifa.rx_data), 32'h11);
        chk("held_valid_A", 32'(ifa.rx_valid), 32'd1);
        set_ready(0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("valid_drop_after_accept_A", 32'(ifa.rx_valid), 32'd0);

        frame(0, 8'h3C, 1'b0, 2'b10, 1'b0);
        expect_frame(0, 16'h0000);
        send(0, 16'h0000, 12, 1'b0);
        chk("busy_after_break_A", 32'(ifa.rx_busy), 32'd0);
        frame(0, 8'h55, 1'b0, 2'b11, 1'b0);

        frame(1, 8'h2A, 1'b0, 2'b11, 1'b0);
        expect_frame(1, 16'h0000);
        send(1, 16'h0000, 12, 1'b0);
        chk("busy_after_break_B", 32'(ifb.rx_busy), 32'd0);
        frame(1, 8'h15, 1'b1, 2'b01, 1'b0);

        fork
            random_frames(0, 5);
            random_frames(1, 5);
        join

        // Abort a frame mid data bit 4 with reset.
        chk("queue_empty_before_reset_A", 32'(qa.size()), 32'd0);
        for (int c = 0; c < CYC * 5 + HALF; c++) begin
            @(negedge clk);
            rx_a = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs_A", 32'({ifa.rx_data, ifa.rx_valid, ifa.rx_parity_err,
            ifa.rx_frame_err, ifa.rx_overrun, ifa.rx_break, ifa.rx_busy}), 32'd0);
        chk("midframe_reset_outputs_B", 32'({ifb.rx_data, ifb.rx_valid, ifb.rx_parity_err,
            ifb.rx_frame_err, ifb.rx_overrun, ifb.rx_break, ifb.rx_busy}), 32'd0);
        @(negedge clk);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        held[0] = 1'b0;
        repeat (20) @(negedge clk);
        frame(0, 8'h81, 1'b0, 2'b11, 1'b0);

        repeat (10) @(negedge clk);
        chk("all_words_delivered_A", 32'(qa.size()), 32'd0);
        chk("all_words_delivered_B", 32'(qb.size()), 32'd0);
        chk("overrun_pulses", 32'(ov_seen), 32'(ov_exp));
        chk("break_pulses", 32'(brk_seen), 32'(brk_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised successor to the fixed 8N1 receiver: configurable data width, parity and stop bits.
- Majority-vote mid-bit sampling, false-start rejection, parity/framing error flags, valid/ready output with overrun detection.
- Sits between the board RX pin and the command/CPU front end; one instance per serial channel.

Parameters:
CLK_FRE, 27, system clock in MHz
BAUD_RATE, 115200, serial baud rate
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1..2

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rx_pin  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, LSB first on the line
rx_valid  output  1  rx_data and error flags valid; held until accepted
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
rx_parity_err  output  1  parity mismatch for the word in rx_data
rx_frame_err  output  1  a checked stop bit sampled low, for the word in rx_data
rx_overrun  output  1  one-cycle pulse when a completed frame is dropped
rx_break  output  1  one-cycle pulse on break detect (see Optional Feature)
rx_busy  output  1  high in every state except IDLE

Behaviour:
- CYCLE = CLK_FRE*1000000/BAUD_RATE (integer); HALF = CYCLE/2. cycle_cnt is 16 bits. CYCLE >= 8 is required.
- Two-flop synchroniser on rx_pin; both flops reset to 1 so reset does not produce a false edge.
- Majority vote: samples taken at cycle_cnt = HALF-2, HALF-1 and HALF. The bit value is the 2-of-3 majority, decided at cycle_cnt == HALF.
- States:
  - IDLE: enter START on synchronised falling edge; cycle_cnt cleared.
  - START: at the decision point, voted 1 -> IDLE (glitch, no output). Voted 0 -> continue; at cycle_cnt == CYCLE-1 go to DATA.
  - DATA: DATA_BITS bits, LSB first, each voted mid-bit. After the last bit's CYCLE-1: go to PARITY if PARITY != 0, else STOP.
  - PARITY: one bit. Error if data XOR parity bit is 0 for odd, or 1 for even. At CYCLE-1 go to STOP.
  - STOP: STOP_BITS bits, each voted mid-bit; any 0 sets frame error. At the decision point of the last stop bit, commit the frame and go to IDLE. Do not wait for the full bit period, to tolerate baud drift.
- cycle_cnt clears on every state change and at CYCLE-1 within DATA, PARITY and STOP (bit boundary).
- Commit (1 clk):
  - rx_valid == 0, or rx_ready == 1 in the same cycle: load rx_data, rx_parity_err and rx_frame_err; set rx_valid = 1.
  - rx_valid == 1 and rx_ready == 0: keep the old word and flags, pulse rx_overrun for 1 cycle.
- Accept without commit: rx_valid && rx_ready clears rx_valid next cycle. rx_data and the flags hold their last values.
- Latency: rx_valid rises 1 clk after the last stop-bit decision point.
- Reset values: rx_data 0, rx_valid 0, rx_parity_err 0, rx_frame_err 0, rx_overrun 0, rx_break 0, rx_busy 0; state IDLE.
- Reset asserted mid-frame aborts the frame; no partial word is delivered.

Optional Feature:
UART_RX_BREAK_EN
- Defined: a frame whose data bits, parity bit (if present) and first stop bit all vote 0 is a break.
  - rx_break pulses 1 cycle at the stop decision point; no commit; rx_valid unchanged.
  - FSM enters BRK_WAIT (rx_busy = 1) until the synchronised line is high, then returns to IDLE.
- Undefined: rx_break is tied 0. The same frame commits as rx_data = 0 with rx_frame_err = 1; parity is evaluated normally.

Test Plan:
- Defaults (CYCLE = 234), rx_ready held 1, send 0xA5 8N1 -> rx_valid pulses 1 clk with rx_data = 0xA5, both errors 0; rx_busy low after commit.
- PARITY = 2, send 0x07 with parity bit 0 (wrong) -> rx_data = 0x07, rx_parity_err = 1. Repeat with parity 1 -> rx_parity_err = 0.
- 50-clk low glitch on idle line -> no rx_valid, FSM back in IDLE by clk ~120. A single-clk high spike inside each data bit of 0x00 -> still rx_data = 0x00.
- rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once at the second commit. Raise rx_ready -> rx_valid drops next cycle.
- Stop bit driven low on 0x3C -> rx_data = 0x3C, rx_frame_err = 1. With UART_RX_BREAK_EN, line held low for 12 bit times -> rx_break pulse, no rx_valid, then 0x55 received correctly.
- Assert rst_n low mid-data-bit 4 of a frame -> all outputs 0; the next full frame 0x81 is received correctly.
